// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//
// Framing stage that sits behind the UART receiver. It hunts for frames of the
// form 0x55 0xAA LEN payload[LEN] CHK and buffers the whole payload. It streams
// the payload on a valid/ready byte interface only when the 8-bit sum of LEN and
// the payload matches CHK. While a stalled frame is in inter-byte silence, a
// timeout abandons it. Bytes that arrive while a frame is being streamed are
// dropped rather than parsed.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   uart_rx_done  one-cycle strobe, uart_rx_data holds a received byte
//   uart_rx_data  received byte
//   frame_data    payload byte on offer
//   frame_valid   frame_data is valid
//   frame_last    final payload byte of the frame
//   frame_ready   consumer accepts the byte on offer
//   frame_len     LEN of the current/last accepted frame
//   frame_ok      pulse: checksum matched, streaming starts
//   frame_err     pulse: bad LEN, checksum mismatch or inter-byte timeout
//   rx_drop       pulse: a byte arrived while streaming and was discarded
module uart_frame_parser #(
  parameter int MAX_LEN      = 16,
  parameter int TIMEOUT_CLKS = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx_done,
  input  logic [7:0] uart_rx_data,
  output logic [7:0] frame_data,
  output logic       frame_valid,
  output logic       frame_last,
  input  logic       frame_ready,
  output logic [7:0] frame_len,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       rx_drop
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR2,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_OUT
  } state_t;

  localparam int          AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  state_t      state, state_n;
  logic [7:0]  wr_ptr, wr_ptr_n;
  logic [7:0]  rd_ptr, rd_ptr_n;
  logic [7:0]  rd_next;
  logic [7:0]  sum, sum_n;
  logic [31:0] tcnt, tcnt_n;
  logic [7:0]  len_n;
  logic [7:0]  data_n;
  logic        valid_n, last_n, ok_n, err_n, drop_n;
  logic        in_frame;
  logic        buf_we;
  logic [7:0]  buf_mem [MAX_LEN];

  assign rd_next  = rd_ptr + 8'd1;
  assign in_frame = (state == S_HDR2) || (state == S_LEN) ||
                    (state == S_PAYLOAD) || (state == S_CHK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      sum         <= '0;
      tcnt        <= '0;
      frame_len   <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_last  <= 1'b0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      rx_drop     <= 1'b0;
    end else begin
      state       <= state_n;
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      sum         <= sum_n;
      tcnt        <= tcnt_n;
      frame_len   <= len_n;
      frame_data  <= data_n;
      frame_valid <= valid_n;
      frame_last  <= last_n;
      frame_ok    <= ok_n;
      frame_err   <= err_n;
      rx_drop     <= drop_n;
    end
  end

  // Payload buffer has no reset; its contents are only read after being written.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_mem[wr_ptr[AW-1:0]] <= uart_rx_data;
    end
  end

  always_comb begin
    state_n  = state;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    sum_n    = sum;
    tcnt_n   = '0;
    len_n    = frame_len;
    data_n   = frame_data;
    valid_n  = frame_valid;
    last_n   = frame_last;
    ok_n     = 1'b0;
    err_n    = 1'b0;
    drop_n   = 1'b0;
    buf_we   = 1'b0;

    if (in_frame && !uart_rx_done) begin
      tcnt_n = tcnt + 32'd1;
    end

    case (state)
      S_IDLE: begin
        if (uart_rx_done && uart_rx_data == 8'h55) begin
          state_n = S_HDR2;
        end
      end
      S_HDR2: begin
        if (uart_rx_done) begin
          if (uart_rx_data == 8'hAA) begin
            state_n = S_LEN;
          end else if (uart_rx_data != 8'h55) begin
            state_n = S_IDLE;
          end
        end
      end
      S_LEN: begin
        if (uart_rx_done) begin
          if (uart_rx_data == 8'd0 || uart_rx_data > MAX_LEN_B) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end else begin
            len_n    = uart_rx_data;
            sum_n    = uart_rx_data;
            wr_ptr_n = '0;
            state_n  = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (uart_rx_done) begin
          buf_we   = 1'b1;
          sum_n    = sum + uart_rx_data;
          wr_ptr_n = wr_ptr + 8'd1;
          if (wr_ptr == frame_len - 8'd1) begin
            state_n = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (uart_rx_done) begin
          if (uart_rx_data == sum) begin
            // First beat is presented together with the ok pulse.
            ok_n     = 1'b1;
            rd_ptr_n = '0;
            valid_n  = 1'b1;
            data_n   = buf_mem[0];
            last_n   = (frame_len == 8'd1);
            state_n  = S_OUT;
          end else begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      S_OUT: begin
        if (uart_rx_done) begin
          drop_n = 1'b1;
        end
        if (frame_valid && frame_ready) begin
          if (frame_last) begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            state_n = S_IDLE;
          end else begin
            // Prefetch the next beat so valid stays high without bubbles.
            rd_ptr_n = rd_next;
            data_n   = buf_mem[rd_next[AW-1:0]];
            last_n   = (rd_next == frame_len - 8'd1);
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // A byte on the terminal count wins over the timeout.
    if (in_frame && !uart_rx_done && tcnt == TO_LAST) begin
      err_n   = 1'b1;
      state_n = S_IDLE;
      tcnt_n  = '0;
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser
//
// Drives byte strobes into uart_frame_parser and holds its outputs against a
// queue-based frame model on every cycle, plus fixed expectations for the
// hand-worked frames.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx_done;
  logic [7:0] uart_rx_data;
  logic [7:0] frame_data;
  logic       frame_valid;
  logic       frame_last;
  logic       frame_ready = 1'b1;
  logic [7:0] frame_len;
  logic       frame_ok;
  logic       frame_err;
  logic       rx_drop;

  uart_frame_parser #(
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rx_done(uart_rx_done),
    .uart_rx_data(uart_rx_data),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_last  (frame_last),
    .frame_ready (frame_ready),
    .frame_len   (frame_len),
    .frame_ok    (frame_ok),
    .frame_err   (frame_err),
    .rx_drop     (rx_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;
  int ready_mode = 0;

  // Reference model state
  logic [7:0] cand[$];
  logic [7:0] out_q[$];
  int         idle = 0;
  logic       m_valid = 0, m_last = 0, m_ok = 0, m_err = 0, m_drop = 0;
  logic [7:0] m_data = 0, m_len = 0;

  // Observed DUT activity
  logic [7:0] hs_data[$];
  logic       hs_last[$];
  int         hs_cyc[$];
  int ok_cnt = 0, err_cnt = 0, drop_cnt = 0, valid_cnt = 0;
  int cyc = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    int s;
    logic [7:0] b;
    cyc++;
    if (frame_valid && frame_ready) begin
      hs_data.push_back(frame_data);
      hs_last.push_back(frame_last);
      hs_cyc.push_back(cyc);
    end
    if (frame_ok)    ok_cnt++;
    if (frame_err)   err_cnt++;
    if (rx_drop)     drop_cnt++;
    if (frame_valid) valid_cnt++;

    m_ok = 0; m_err = 0; m_drop = 0;
    if (rst) begin
      cand.delete(); out_q.delete(); idle = 0;
      m_valid = 0; m_last = 0; m_data = 0; m_len = 0;
    end else if (out_q.size() > 0) begin
      if (uart_rx_done) m_drop = 1;
      if (m_valid && frame_ready) void'(out_q.pop_front());
      if (out_q.size() > 0) begin
        m_data = out_q[0];
        m_last = (out_q.size() == 1);
      end else begin
        m_valid = 0;
        m_last  = 0;
      end
    end else if (uart_rx_done) begin
      idle = 0;
      b = uart_rx_data;
      if (cand.size() == 0) begin
        if (b == 8'h55) cand.push_back(b);
      end else if (cand.size() == 1) begin
        if (b == 8'hAA) cand.push_back(b);
        else if (b != 8'h55) cand.delete();
      end else if (cand.size() == 2) begin
        if (b == 0 || b > MAX_LEN) begin
          m_err = 1;
          cand.delete();
        end else begin
          m_len = b;
          cand.push_back(b);
        end
      end else if (cand.size() < 3 + int'(cand[2])) begin
        cand.push_back(b);
      end else begin
        s = 0;
        for (int i = 2; i < cand.size(); i++) s += cand[i];
        if (s % 256 == int'(b)) begin
          m_ok = 1;
          for (int i = 3; i < cand.size(); i++) out_q.push_back(cand[i]);
          m_valid = 1;
          m_data  = out_q[0];
          m_last  = (out_q.size() == 1);
        end else begin
          m_err = 1;
        end
        cand.delete();
      end
    end else if (cand.size() > 0) begin
      idle++;
      if (idle == TMO) begin
        m_err = 1;
        cand.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("frame_valid", frame_valid, m_valid);
      checkOutput("frame_ok", frame_ok, m_ok);
      checkOutput("frame_err", frame_err, m_err);
      checkOutput("rx_drop", rx_drop, m_drop);
      checkOutput("frame_len", frame_len, m_len);
      if (m_valid) begin
        checkOutput("frame_data", frame_data, m_data);
        checkOutput("frame_last", frame_last, m_last);
      end
    end
  end

  always @(negedge clk) begin
    case (ready_mode)
      0: frame_ready = 1'b1;
      1: frame_ready = 1'($urandom_range(0, 1));
      2: frame_ready = 1'b0;
      default: frame_ready = ~frame_ready;
    endcase
  end

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    @(negedge clk);
    uart_rx_done = 1'b1;
    uart_rx_data = b;
    @(negedge clk);
    uart_rx_done = 1'b0;
    uart_rx_data = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendBytes(input logic [7:0] bytes[$]);
    foreach (bytes[i]) applyStimulus(bytes[i], int'($urandom_range(0, 2)));
  endtask

  task automatic clearLogs();
    hs_data.delete(); hs_last.delete(); hs_cyc.delete();
    ok_cnt = 0; err_cnt = 0; drop_cnt = 0; valid_cnt = 0;
  endtask

  task automatic waitIdle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cand.size() == 0 && out_q.size() == 0 && !m_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput("wait_idle_bound", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic waitValid(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput("wait_valid_bound", 0, 1);
  endtask

  task automatic checkBeats(input string tag, input logic [7:0] exp[$]);
    checkOutput({tag, "_beats"}, hs_data.size(), exp.size());
    if (hs_data.size() == exp.size()) begin
      foreach (exp[i]) begin
        checkOutput({tag, "_beat_data"}, hs_data[i], exp[i]);
        checkOutput({tag, "_beat_last"}, hs_last[i], (i == exp.size() - 1) ? 1 : 0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    int len, kind, s;
    rst = 1'b1;
    uart_rx_done = 1'b0;
    uart_rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", frame_valid, 0);
    checkOutput("reset_len", frame_len, 0);
    checkOutput("reset_pulses", {frame_ok, frame_err, rx_drop}, 0);
    rst = 1'b0;
    chk_en = 1;

    // Good frame, ready held high
    clearLogs();
    sendBytes('{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
    waitIdle(200);
    checkBeats("good", '{8'h11, 8'h22, 8'h33});
    if (hs_cyc.size() == 3) begin
      checkOutput("good_gap1", hs_cyc[1] - hs_cyc[0], 1);
      checkOutput("good_gap2", hs_cyc[2] - hs_cyc[1], 1);
    end
    checkOutput("good_ok_cnt", ok_cnt, 1);
    checkOutput("good_err_cnt", err_cnt, 0);
    checkOutput("good_len", frame_len, 3);

    // Bad checksum
    clearLogs();
    sendBytes('{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A});
    waitIdle(200);
    checkOutput("badchk_err_cnt", err_cnt, 1);
    checkOutput("badchk_valid_cnt", valid_cnt, 0);

    // LEN=0 and LEN=17, each followed by a one-byte frame
    clearLogs();
    sendBytes('{8'h55, 8'hAA, 8'h00});
    sendBytes('{8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F});
    waitIdle(200);
    checkOutput("len0_err_cnt", err_cnt, 1);
    checkBeats("len0", '{8'h7E});
    clearLogs();
    sendBytes('{8'h55, 8'hAA, 8'h11});
    sendBytes('{8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F});
    waitIdle(200);
    checkOutput("len17_err_cnt", err_cnt, 1);
    checkBeats("len17", '{8'h7E});

    // Resync and garbage before the header
    clearLogs();
    sendBytes('{8'h55, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F});
    waitIdle(200);
    checkBeats("resync", '{8'h7E});
    clearLogs();
    sendBytes('{8'h12, 8'h55, 8'h34, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F});
    waitIdle(200);
    checkBeats("garbage", '{8'h7E});
    checkOutput("garbage_ok_cnt", ok_cnt, 1);

    // Backpressure with a byte injected while stalled
    clearLogs();
    ready_mode = 2;
    sendBytes('{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
    waitValid(50);
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_data", frame_data, 8'h11);
    end
    applyStimulus(8'h55, 0);
    checkOutput("stall_data_after_drop", frame_data, 8'h11);
    ready_mode = 3;
    waitIdle(200);
    ready_mode = 0;
    checkBeats("bp", '{8'h11, 8'h22, 8'h33});
    checkOutput("bp_drop_cnt", drop_cnt, 1);

    // Inter-byte timeout, then a normal frame
    clearLogs();
    sendBytes('{8'h55, 8'hAA, 8'h04, 8'h01, 8'h02});
    repeat (TMO + 20) @(negedge clk);
    checkOutput("tmo_err_cnt", err_cnt, 1);
    sendBytes('{8'h55, 8'hAA, 8'h02, 8'h10, 8'h20, 8'h32});
    waitIdle(200);
    checkBeats("after_tmo", '{8'h10, 8'h20});
    checkOutput("after_tmo_err_cnt", err_cnt, 1);

    // Randomised traffic
    for (int f = 0; f < 40; f++) begin
      ready_mode = 1;
      fr.delete();
      kind = int'($urandom_range(0, 5));
      if (kind == 5) begin
        repeat ($urandom_range(1, 4)) fr.push_back(8'($urandom));
      end
      len = int'($urandom_range(1, MAX_LEN));
      if (kind == 3) len = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(MAX_LEN + 1, 255));
      fr.push_back(8'h55); fr.push_back(8'hAA); fr.push_back(8'(len));
      if (kind != 3) begin
        s = len;
        for (int i = 0; i < len; i++) begin
          fr.push_back(8'($urandom));
          s += fr[fr.size() - 1];
        end
        fr.push_back((kind == 4) ? 8'(s + 1) : 8'(s));
      end
      sendBytes(fr);
      if ($urandom_range(0, 2) == 0) applyStimulus(8'($urandom), 0);
      waitIdle(400);
    end
    ready_mode = 0;

    // Reset during streaming
    ready_mode = 2;
    sendBytes('{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
    waitValid(50);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_out_valid", frame_valid, 0);
    checkOutput("rst_out_len", frame_len, 0);
    checkOutput("rst_out_pulses", {frame_ok, frame_err, rx_drop}, 0);
    rst = 1'b0;
    ready_mode = 0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-level framing stage directly downstream of the UART receiver. It consumes the receiver's one-cycle `uart_rx_done` / `uart_rx_data` byte strobes and recognises frames of the form 0x55, 0xAA, LEN, LEN payload bytes, CHK. Each frame is buffered whole and its checksum checked. Only verified payloads are streamed out on a valid/ready byte interface to the command layer.

## Interface
Parameters:
- `MAX_LEN`, default 16: largest accepted LEN value; also the payload buffer depth (1..255).
- `TIMEOUT_CLKS`, default 100_000: number of idle clocks between bytes inside a frame before the frame is abandoned.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `uart_rx_done`  in  1  one-cycle pulse; a received byte is present on `uart_rx_data`.
- `uart_rx_data`  in  8  received byte; sampled only when `uart_rx_done`=1.
- `frame_data`  out  8  payload byte being offered.
- `frame_valid`  out  1  `frame_data` is valid.
- `frame_last`  out  1  asserted with the final payload byte of the frame.
- `frame_ready`  in  1  consumer accepts the byte.
- `frame_len`  out  8  LEN of the frame being streamed; held until the next LEN is accepted.
- `frame_ok`  out  1  one-cycle pulse; the checksum matched.
- `frame_err`  out  1  one-cycle pulse on a bad LEN, a checksum mismatch or a timeout.
- `rx_drop`  out  1  one-cycle pulse; a byte arrived during OUT and was discarded.

## Operation
- States are IDLE, HDR2, LEN, PAYLOAD, CHK and OUT. State advances only on `uart_rx_done`, except for the timeout and the OUT state.
- **IDLE**
  - byte 0x55 -> HDR2.
  - any other byte is ignored.
- **HDR2**
  - 0xAA -> LEN.
  - 0x55 -> stay in HDR2 (resync).
  - any other byte -> IDLE, with no error.
- **LEN**
  - LEN=0 or LEN>`MAX_LEN` -> `frame_err` pulse, then IDLE.
  - otherwise latch `frame_len`, set sum=LEN, clear wr_ptr, go to PAYLOAD.
- **PAYLOAD**
  - Each byte is written to buf[wr_ptr]; sum += byte (mod 256); wr_ptr++.
  - After the LEN-th byte -> CHK.
- **CHK**
  - byte == sum -> `frame_ok` pulse, rd_ptr=0, go to OUT.
  - otherwise `frame_err` pulse, then IDLE.
- **OUT**
  - Presents buf[rd_ptr].
  - A handshake (`frame_valid`&&`frame_ready`) increments rd_ptr.
  - The handshake on rd_ptr=LEN-1 (`frame_last`=1) -> IDLE.
  - A `uart_rx_done` in OUT is discarded and pulses `rx_drop`. It is not parsed, even if it is 0x55.
- **Checksum**: 8-bit unsigned sum of LEN and all payload bytes, modulo 256.
- **Timeout**
  - In HDR2/LEN/PAYLOAD/CHK, a counter clears on every `uart_rx_done` and increments otherwise.
  - On reaching `TIMEOUT_CLKS`-1 without a byte -> `frame_err` pulse, then IDLE.
  - The counter is held at 0 in IDLE and OUT.
- Error and timeout paths never assert `frame_valid`. The buffer contents are not cleared.
- **Reset values**: all outputs 0, state IDLE, pointers/sum/timeout 0.
  - `frame_len` resets to 0.
  - Reset asserted mid-frame or mid-OUT aborts the frame; `frame_valid` is 0 on the cycle after `rst` is sampled high.

## Timing
- All outputs are registered.
- `frame_ok` and `frame_err` pulse in the cycle after the deciding `uart_rx_done`.
- `frame_valid` rises in the same cycle as `frame_ok`, with buf[0] on `frame_data`.
- **Throughput**: one byte per clock while `frame_ready`=1. Bubble-free; `frame_valid` stays high across consecutive beats.
- While `frame_valid`=1 and `frame_ready`=0, `frame_data` and `frame_last` are held stable.
- `frame_valid` falls in the cycle after the last handshake.
- A 0x55 arriving in the first IDLE cycle after OUT is accepted.
- A `uart_rx_done` coinciding with the timeout terminal count takes priority: the byte is processed and no error is raised.
- `rx_drop` pulses in the cycle after the discarded byte's `uart_rx_done`.

## Test plan
- Bytes 55 AA 03 11 22 33 69 with `frame_ready`=1:
  - `frame_ok` pulses once and `frame_len`=3;
  - beats 11, 22, 33 on consecutive cycles, with `frame_last` only on 33;
  - `frame_err` never asserts.
- Same frame with CHK=6A: `frame_err` pulses once, one cycle after the CHK byte; `frame_valid` is never asserted.
- 55 AA 00 and, separately, 55 AA 11 (LEN=17 > `MAX_LEN`):
  - `frame_err` pulses after the LEN byte;
  - a following valid frame 55 AA 01 7E 7F streams 7E with `frame_last`=1.
- 55 55 AA 01 7E 7F (resync) is accepted. 12 55 34 55 AA 01 7E 7F yields exactly one frame (7E).
- Backpressure on 55 AA 03 11 22 33 69:
  - hold `frame_ready`=0 for 5 cycles, then toggle it;
  - `frame_data` stays 11 while stalled; exactly 3 handshakes occur, with correct order and `frame_last`;
  - a byte injected during OUT pulses `rx_drop` and does not change the output.
- Timeout and reset:
  - with `TIMEOUT_CLKS`=50, send 55 AA 04 01 02 and stop: `frame_err` pulses once, and the next full frame is parsed normally;
  - asserting `rst` during OUT drives `frame_valid`, `frame_len` and all pulse outputs to 0 on the following cycle.
